// File: rtl/lumi_regs_mc.sv
// lumi_regs_mc: multi-channel LUMI CSR file with per-channel link FSM, credit config, link-down counter and stall watchdog.
module lumi_regs_mc #(
  parameter int N = 2,
  parameter int INITIOW = 0,
  parameter int CRDTDEPTH = 37,
  parameter int RETRAIN_CYC = 16,
  parameter int RW = 32
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic            devicemode,
  input  logic            deviceready,
  input  logic [N-1:0]    phy_linkactive,
  input  logic [N-1:0]    txcrdt_stall,
  input  logic [32*N-1:0] csr_txcrdt_status,
  input  logic            reg_valid,
  input  logic            reg_write,
  input  logic [11:0]     reg_addr,
  input  logic [RW-1:0]   reg_wrdata,
  output logic            reg_ready,
  output logic            reg_rdvalid,
  output logic [RW-1:0]   reg_rddata,
  input  logic            reg_rdready,
  output logic [N-1:0]    host_linkactive,
  output logic [N-1:0]    csr_txen,
  output logic [N-1:0]    csr_rxen,
  output logic [N-1:0]    csr_txcrdt_en,
  output logic [2*N-1:0]  csr_arbmode,
  output logic [8*N-1:0]  csr_txiowidth,
  output logic [8*N-1:0]  csr_rxiowidth,
  output logic [16*N-1:0] csr_txcrdt_intrvl,
  output logic [16*N-1:0] csr_rxcrdt_req_init,
  output logic [16*N-1:0] csr_rxcrdt_resp_init,
  output logic            irq
);
  typedef enum logic [1:0] {DOWN, WAIT, ACTIVE, RETRAIN} state_t;
  logic wr, rd, unused_addr;
  logic [3:0] page;
  logic [5:0] off;
  logic [RW-1:0] rv [16];
  logic [RW-1:0] inten, rd_mux;
  logic [N-1:0] ld, wd;
  assign reg_ready = ~reg_rdvalid | reg_rdready;
  assign wr = reg_valid & reg_ready & reg_write;
  assign rd = reg_valid & reg_ready & ~reg_write;
  assign page = reg_addr[11:8];
  assign off = reg_addr[7:2];
  assign unused_addr = ^reg_addr[1:0];
  assign irq = |(ld & inten[N-1:0]) | |(wd & inten[16+:N]);
  // Pages 0..15 always have a read slot; absent channels read as zero.
  for (genvar g = 0; g < 16; g++) begin : ch
    if (g < N) begin : on
      state_t st, st_nx;
      logic [15:0] rt, rt_nx, iow, intr, ldc, lim, wdc;
      logic [31:0] cinit;
      logic [2:0] ctl;
      logic [1:0] arb;
      logic sel, phy, act, ld_set, wd_en, wd_hit, retrain, ldk, wdk;
      assign sel = wr & (page == 4'(g));
      assign phy = phy_linkactive[g];
      assign act = st == ACTIVE;
      assign ld_set = act & ~phy;
      assign retrain = sel & (off == 6'd0) & reg_wrdata[8];
      assign wd_en = act & ctl[2] & (lim != '0) & txcrdt_stall[g];
      assign wd_hit = (lim != '0) & (wdc == lim);
      always_comb begin
        st_nx = st;
        rt_nx = '0;
        case (st)
          DOWN:    st_nx = phy ? WAIT : DOWN;
          WAIT:    st_nx = !phy ? DOWN : (~devicemode | deviceready) ? ACTIVE : WAIT;
          ACTIVE:  st_nx = !phy ? DOWN : retrain ? RETRAIN : ACTIVE;
          RETRAIN: begin
            st_nx = (rt == 16'(RETRAIN_CYC - 1)) ? DOWN : RETRAIN;
            rt_nx = rt + 16'd1;
          end
          default: st_nx = DOWN;
        endcase
      end
      always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
          st <= DOWN;
          rt <= '0;
          ctl <= 3'b011;
          arb <= '0;
          ldk <= 1'b0;
          wdk <= 1'b0;
          iow <= {8'(INITIOW), 8'(INITIOW)};
          cinit <= {16'(CRDTDEPTH), 16'(CRDTDEPTH)};
          intr <= 16'h00FF;
          ldc <= '0;
          lim <= '0;
          wdc <= '0;
        end else begin
          st <= st_nx;
          rt <= rt_nx;
          if (sel & (off == 6'd0)) begin
            ctl <= reg_wrdata[2:0];
            arb <= reg_wrdata[5:4];
          end
          ldk <= ld_set | (ldk & ~(sel & (off == 6'd1) & reg_wrdata[8]));
          wdk <= wd_hit | (wdk & ~(sel & (off == 6'd1) & reg_wrdata[9]));
          if (sel & (off == 6'd2)) iow <= reg_wrdata[15:0];
          if (sel & (off == 6'd3)) cinit <= reg_wrdata[31:0];
          if (sel & (off == 6'd4)) intr <= reg_wrdata[15:0];
          if (sel & (off == 6'd6)) ldc <= {15'b0, ld_set};
          else if (ld_set & ~&ldc) ldc <= ldc + 16'd1;
          if (sel & (off == 6'd7)) lim <= reg_wrdata[15:0];
          wdc <= !wd_en ? '0 : wd_hit ? wdc : wdc + 16'd1;
        end
      end
      assign ld[g] = ldk;
      assign wd[g] = wdk;
      assign rv[g] = off == 6'd0 ? {26'b0, arb, 1'b0, ctl} :
                     off == 6'd1 ? {22'b0, wdk, ldk, 5'b0, st, act} :
                     off == 6'd2 ? {16'b0, iow} :
                     off == 6'd3 ? cinit :
                     off == 6'd4 ? {16'b0, intr} :
                     off == 6'd5 ? csr_txcrdt_status[32*g+:32] :
                     off == 6'd6 ? {16'b0, ldc} :
                     off == 6'd7 ? {16'b0, lim} : '0;
      assign host_linkactive[g] = act;
      assign csr_txen[g] = act & ctl[0];
      assign csr_rxen[g] = act & ctl[1];
      assign csr_txcrdt_en[g] = ctl[2];
      assign csr_arbmode[2*g+:2] = arb;
      assign csr_txiowidth[8*g+:8] = iow[7:0];
      assign csr_rxiowidth[8*g+:8] = iow[15:8];
      assign csr_txcrdt_intrvl[16*g+:16] = intr;
      assign csr_rxcrdt_req_init[16*g+:16] = cinit[15:0];
      assign csr_rxcrdt_resp_init[16*g+:16] = cinit[31:16];
    end else begin : off_ch
      assign rv[g] = '0;
    end
  end
  assign rd_mux = page == 4'hF ? (off == 6'd0 ? inten : '0) : rv[page];
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      inten <= '0;
      reg_rdvalid <= 1'b0;
      reg_rddata <= '0;
    end else begin
      if (wr & (page == 4'hF) & (off == 6'd0)) inten <= reg_wrdata;
      if (rd) begin
        reg_rdvalid <= 1'b1;
        reg_rddata <= rd_mux;
      end else if (reg_rdready) reg_rdvalid <= 1'b0;
    end
  end
endmodule
